// File: rtl/uart_tx_stream.sv
// uart_tx_stream: FIFO-buffered UART transmitter (start, data LSB first, optional parity, stop); tx idles high.
// Latency: a byte pushed into an empty idle FIFO at edge N pops at N+1 and tx falls after N+1; tx is registered.
// Backpressure: in_ready drops while the FIFO is full; UART_TX_GAP_EN adds GAP_BITS idle bit periods between frames.
module uart_tx_stream #(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
`ifdef UART_TX_GAP_EN
  ,
  parameter int GAP_BITS     = 1
`endif
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic                 push, pop;

  state_t               state, state_nxt;
  logic [CW-1:0]        cnt, cnt_nxt;
  logic [3:0]           bit_idx, bit_idx_nxt;
  logic [DATA_BITS-1:0] shift, shift_nxt;
  logic                 par_bit, par_nxt;
  logic                 tx_nxt;
  logic                 tick;
  logic                 gap_ok;

  assign in_ready = (level != LVL_FULL);
  assign push     = in_valid && in_ready;
  assign busy     = (state != S_IDLE) || (level != '0);
  assign tick     = (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      level <= level + 1'b1;
      else if (pop && !push) level <= level - 1'b1;
    end
  end

  // Storage needs no reset: pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

`ifdef UART_TX_GAP_EN
  localparam int GAP_CYCLES = GAP_BITS * CLKS_PER_BIT;
  localparam int GW = $clog2(GAP_CYCLES + 1);
  logic [GW-1:0] gap_cnt;

  // Loaded on STOP->IDLE so IDLE lasts GAP_CYCLES cycles; zero after reset so the first frame is not delayed.
  always_ff @(posedge clk) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == S_STOP && state_nxt == S_IDLE) begin
      gap_cnt <= GW'(GAP_CYCLES - 1);
    end else if (state == S_IDLE && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end
  assign gap_ok = (gap_cnt == '0);
`else
  assign gap_ok = 1'b1;
`endif

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift;
    par_nxt     = par_bit;
    pop         = 1'b0;
    tx_nxt      = 1'b1;
    if (state != S_IDLE) cnt_nxt = tick ? '0 : cnt + 1'b1;
    case (state)
      S_IDLE: begin
        if (level != '0 && gap_ok) begin
          pop         = 1'b1;
          shift_nxt   = mem[rd_ptr];
          par_nxt     = (PARITY == 1) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = S_START;
        end
      end
      S_START: if (tick) state_nxt = S_DATA;
      S_DATA: begin
        if (tick) begin
          shift_nxt = shift >> 1;
          if (bit_idx == DATA_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      S_PARITY: if (tick) state_nxt = S_STOP;
      S_STOP: begin
        if (tick) begin
          if (bit_idx == STOP_LAST) begin
            bit_idx_nxt = '0;
            state_nxt   = S_IDLE;
          end else begin
            bit_idx_nxt = bit_idx + 1'b1;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    // tx is derived from the next state so the line register changes on the transition edge.
    case (state_nxt)
      S_START:  tx_nxt = 1'b0;
      S_DATA:   tx_nxt = shift_nxt[0];
      S_PARITY: tx_nxt = par_nxt;
      default:  tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      par_bit <= 1'b0;
      tx      <= 1'b1;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      bit_idx <= bit_idx_nxt;
      shift   <= shift_nxt;
      par_bit <= par_nxt;
      tx      <= tx_nxt;
    end
  end

endmodule

// File: tb/tb_uart_tx_stream.sv
// Bench for uart_tx_stream: 8E2 framing, 4 clocks per bit, 4-entry FIFO, checked every cycle against a frame-level model.
module tb_uart_tx_stream;

  localparam int CPB   = 4;
  localparam int DW    = 8;
  localparam int PAR   = 2;
  localparam int SB    = 2;
  localparam int DEPTH = 4;
  localparam int FRAME_LEN = (1 + DW + ((PAR != 0) ? 1 : 0) + SB) * CPB;
`ifdef UART_TX_GAP_EN
  localparam int GAP = 1;
  localparam int MIN_IDLE = GAP * CPB;
`else
  localparam int MIN_IDLE = 1;
`endif

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [DW-1:0]             in_data;
  logic                      tx;
  logic                      busy;
  logic [$clog2(DEPTH):0]    level;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  uart_tx_stream #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(DW), .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
`ifdef UART_TX_GAP_EN
    , .GAP_BITS(GAP)
`endif
  ) u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .tx(tx), .busy(busy), .level(level)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Frame-level model: FIFO as a queue, active frame as (byte, cycle position).
  logic [DW-1:0] q[$];
  logic [DW-1:0] m_byte;
  bit            m_active = 1'b0;
  bit            m_known  = 1'b0;
  bit            m_push;
  int            m_pos    = 0;
  int            m_idle   = 0;

  function automatic logic frame_bit(input logic [DW-1:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= DW) return d[k-1];
    if (PAR != 0 && k == DW + 1) return (PAR == 1) ? ~^d : ^d;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      m_active = 1'b0;
      m_pos    = 0;
      m_idle   = MIN_IDLE;
      m_known  = 1'b1;
    end else if (m_known) begin
      m_push = in_valid && (q.size() < DEPTH);
      if (m_active) begin
        m_pos++;
        if (m_pos == FRAME_LEN) begin
          m_active = 1'b0;
          m_idle   = 1;
        end
      end else if (q.size() != 0 && m_idle >= MIN_IDLE) begin
        m_byte   = q.pop_front();
        m_active = 1'b1;
        m_pos    = 0;
      end else if (m_idle < MIN_IDLE) begin
        m_idle++;
      end
      if (m_push) q.push_back(in_data);
    end
  end

  logic exp_tx;
  int   exp_lvl;
  always @(negedge clk) begin
    if (m_known) begin
      exp_tx  = m_active ? frame_bit(m_byte, m_pos / CPB) : 1'b1;
      exp_lvl = q.size();
      chk("model_tx",       32'(tx),       32'(exp_tx));
      chk("model_level",    32'(level),    32'(exp_lvl));
      chk("model_in_ready", 32'(in_ready), (exp_lvl != DEPTH) ? 32'd1 : 32'd0);
      chk("model_busy",     32'(busy),     (m_active || exp_lvl != 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic wait_idle(input int budget, input string nm);
    int n;
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(busy), 32'd0);
    repeat (MIN_IDLE) @(negedge clk);
  endtask

  // Sends one byte from an idle, empty FIFO and checks each bit mid-period against a hand-written pattern (bit 0 = start).
  task automatic send_frame(input logic [DW-1:0] b, input logic [11:0] pat, input string nm);
    int n;
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
    chk({nm, "_level_after_push"}, 32'(level), 32'd1);
    chk({nm, "_tx_before_pop"},    32'(tx),    32'd1);
    @(negedge clk);
    chk({nm, "_level_after_pop"},  32'(level), 32'd0);
    chk({nm, "_tx_start_edge"},    32'(tx),    32'd0);
    for (int k = 0; k < 12; k++) begin
      repeat ((k == 0) ? 1 : CPB) @(negedge clk);
      chk({nm, "_bit"}, 32'(tx), 32'(pat[k]));
    end
    n = 0;
    while (busy !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_frame_end"}, n, 3);
    repeat (MIN_IDLE) @(negedge clk);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  b;
    int  g;
    bit  acc;
    bit  saw_full;

    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    chk("reset_tx",       32'(tx),       32'd1);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_busy",     32'(busy),     32'd0);
    chk("reset_level",    32'(level),    32'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // 0x55 even parity: start 0, data 1010_1010 LSB first, parity 0, stop 1 1
    send_frame(8'h55, 12'b1100_1010_1010, "b55");
    // 0x07: data 1110_0000 LSB first, parity 1
    send_frame(8'h07, 12'b1110_0000_1110, "b07");

    // Six bytes with in_valid held: FIFO must fill and stall the source.
    b = 1; g = 0; saw_full = 1'b0;
    in_valid = 1'b1;
    in_data  = 8'(b);
    while (b <= 6 && g < 2000) begin
      acc = in_ready;
      @(negedge clk);
      g++;
      if (acc) b++;
      if (!in_ready) saw_full = 1'b1;
      in_data = 8'(b);
    end
    in_valid = 1'b0;
    chk("burst_all_accepted", b, 7);
    chk("burst_full_seen", 32'(saw_full), 32'd1);
    wait_idle(8 * FRAME_LEN, "burst_drain");

    // Push at edge N, push again at N+1 while the first pops: level holds at 1.
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    chk("pushpop_level_pre", 32'(level), 32'd1);
    in_data = 8'h3E;
    @(negedge clk);
    in_valid = 1'b0;
    chk("pushpop_level_same", 32'(level), 32'd1);
    wait_idle(4 * FRAME_LEN, "pushpop_drain");

    // Four bytes: one in flight, three queued; reset at frame cycle 10.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 8'(8'hA1 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("abort_level_queued", 32'(level), 32'd3);
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_tx",       32'(tx),       32'd1);
    chk("abort_level",    32'(level),    32'd0);
    chk("abort_busy",     32'(busy),     32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    // 0x3C: data 0011_1100 LSB first, parity 0
    send_frame(8'h3C, 12'b1100_0111_1000, "b3c");

    // Random traffic with occasional resets, checked by the model every cycle.
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 3) == 0);
      in_data  = 8'($urandom);
      reset    = ($urandom_range(0, 999) == 0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    reset    = 1'b0;
    wait_idle((DEPTH + 2) * FRAME_LEN, "random_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_stream.md
Name: uart_tx_stream

Overview:
- Synthesizable, parametrised UART transmitter with input FIFO; drives the board `uart_rx` line from a valid/ready byte stream.
- Serves as the bench-side byte driver in simulation and as a loopback/debug transmitter in hardware.
- Generalises fixed 8N1 at 115200 to configurable bit period, data width, parity, stop bits and buffering.

Parameters:
CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200); must be >= 2
DATA_BITS, 8, data bits per frame, 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop bits per frame, 1 or 2
FIFO_DEPTH, 16, input FIFO entries, power of two, >= 2

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  byte offered
in_ready  out  1  FIFO can accept (not full)
in_data  in  DATA_BITS  byte to send, LSB first
tx  out  1  serial line, idle high
busy  out  1  frame in progress or FIFO non-empty
level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. While reset is asserted every register clears on the next edge.
- Reset values: tx=1, in_ready=1, busy=0, level=0. FSM=IDLE, baud counter=0, bit index=0.
- Reset mid-frame aborts the frame immediately: tx returns to 1 on the following edge and FIFO contents are discarded.
- FIFO write occurs when in_valid && in_ready. in_ready = (level != FIFO_DEPTH), combinational from level.
- Pop occurs only on the IDLE->START transition. A same-cycle push and pop leaves level unchanged.
- A push into a full FIFO is impossible because in_ready=0; in_data is ignored.
- Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If level!=0, pop, latch the byte into the shift register, compute the parity bit, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit; shift right; DATA_BITS bits total.
  - PARITY (skipped if PARITY==0): tx = odd ? ~^data : ^data, for one bit period.
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles, then IDLE.
- Baud counter counts 0..CLKS_PER_BIT-1. State and bit advances happen when the counter reaches CLKS_PER_BIT-1, and the counter then resets to 0.
- Latency: a byte pushed into an empty, idle FIFO at edge N is popped at edge N+1 (level visible =1 for one cycle). tx falls after edge N+1.
- Frame length is (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Back-to-back: if the FIFO is non-empty on leaving STOP, IDLE lasts exactly one cycle before the next START.
- tx is registered; there are no combinational paths to tx.
- busy = (state != IDLE) || (level != 0).

Optional Feature:
- Macro: UART_TX_GAP_EN.
- Defined:
  - Adds parameter GAP_BITS (default 1).
  - IDLE holds tx=1 for at least GAP_BITS*CLKS_PER_BIT cycles after every STOP before the next pop. This matches a line-idle bit period before each start bit.
  - Gap counting restarts after reset; the first frame after reset is not delayed.
  - busy stays 1 during the gap if the FIFO is non-empty.
- Not defined: no gap logic; the one-cycle IDLE back-to-back behaviour applies.

Test Plan:
1. CLKS_PER_BIT=4, 8N1: push 0x55 once -> after a 1-cycle pop, tx = 0,1,0,1,0,1,0,1,0,1, each bit held 4 cycles (40 cycles total); busy falls the cycle after STOP ends; level returns to 0.
2. CLKS_PER_BIT=4, PARITY=2, STOP_BITS=2: push 0x07 -> data bits 1,1,1,0,0,0,0,0, parity bit 1, stop high for 8 cycles; frame = 48 cycles.
3. FIFO_DEPTH=4: push 6 bytes 0x01..0x06 with in_valid held -> in_ready drops while level=4. Bytes are transmitted in order 0x01..0x06 with exactly one idle cycle between frames and no loss.
4. Simultaneous push/pop: level=1 in IDLE with in_valid=1 -> level stays 1 and the new byte is sent as the next frame.
5. Assert reset at cycle 10 of a frame with 3 bytes queued -> the next cycle has tx=1, level=0, busy=0, in_ready=1; a subsequent push transmits normally.
6. UART_TX_GAP_EN, GAP_BITS=1, CLKS_PER_BIT=4: push 2 bytes -> the second start bit begins exactly 4 cycles after the first frame's STOP ends (the first frame is not delayed).
